// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter; start bit, DATA_WIDTH data bits LSB-first, optional parity, stop bit, prescale cycles per bit
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clck,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [5:0]            prescale,
  output logic                  tx_out,
  output logic                  busy
);
  localparam int IW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state_q, state_d;
  logic [5:0]            timer_q, timer_d, presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d, par_q, par_d, tx_q, tx_d, busy_q, busy_d;
  logic                  adv;
  assign adv = timer_q == presc_q;
  always_comb begin
    state_d  = state_q;
    timer_d  = adv ? 6'd1 : timer_q + 6'd1;
    presc_d  = presc_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        timer_d = 6'd1;
        if (data_valid) begin
          state_d  = START;
          data_d   = p_data;
          par_en_d = par_en;
          par_d    = ^p_data ^ par_typ;
          presc_d  = prescale == 6'd0 ? 6'd1 : prescale;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: if (adv) begin
        state_d = DATA;
        idx_d   = '0;
        tx_d    = data_q[0];
      end
      DATA: if (adv) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(DATA_WIDTH - 1)) begin
          state_d = par_en_q ? PARITY : STOP;
          tx_d    = par_en_q ? par_q : 1'b1;
        end else tx_d = data_q[idx_d];
      end
      PARITY: if (adv) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (adv) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
      default: begin
        state_d = IDLE;
        timer_d = 6'd1;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clck) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end
  assign tx_out = tx_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench checking every serial cycle of each frame and the idle line between frames
module tb_uart_tx_frame;
  logic       clck = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = '0;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] prescale = 6'd1;
  logic       tx_out, busy;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clck(clck), .rst(rst), .p_data(p_data), .data_valid(data_valid), .par_en(par_en),
    .par_typ(par_typ), .prescale(prescale), .tx_out(tx_out), .busy(busy)
  );

  always #5 clck = ~clck;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       par;
    int         p;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   pass_cnt = 0, total_cnt = 0;
  bit   mon_en = 0, active = 0;
  int   cyc = 0, b = 0, idle_run = 0, last_gap = 0, frames = 0;
  logic eb;

  always @(negedge clck) if (mon_en) begin
    if (!active && busy === 1'b1 && sb.size() > 0) begin
      cur = sb.pop_front();
      active = 1;
      cyc = 0;
      last_gap = idle_run;
      idle_run = 0;
    end
    if (active) begin
      b = cyc / cur.p;
      eb = b == 0 ? 1'b0 : b <= 8 ? cur.d[3'(b - 1)] : (b == 9 && cur.pe) ? cur.par : 1'b1;
      total_cnt++;
      if (tx_out !== eb || busy !== 1'b1)
        $display("FAIL frame %02h cycle %0d: tx_out=%b busy=%b, required tx_out=%b busy=1", cur.d, cyc, tx_out, busy, eb);
      else pass_cnt++;
      cyc++;
      if (cyc == cur.p * (cur.pe ? 11 : 10) || rst === 1'b1) begin
        active = 0;
        frames++;
      end
    end else begin
      idle_run++;
      total_cnt++;
      if (busy !== 1'b0 || tx_out !== 1'b1)
        $display("FAIL idle line: tx_out=%b busy=%b, required tx_out=1 busy=0", tx_out, busy);
      else pass_cnt++;
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    exp_t e;
    @(posedge clck); #1;
    p_data = d; par_en = pe; par_typ = pt; prescale = ps; data_valid = 1'b1;
    e.d = d; e.pe = pe; e.par = ^d ^ pt; e.p = ps == 6'd0 ? 1 : int'(ps);
    sb.push_back(e);
    @(posedge clck); #1;
    data_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && (sb.size() > 0 || active); i++) @(negedge clck);
    total_cnt++;
    if (sb.size() > 0 || active) $display("FAIL frame timeout: pending=%0d active=%0d, required 0/0", sb.size(), active);
    else pass_cnt++;
    repeat (3) @(negedge clck);
  endtask

  task automatic test_reset();
    data_valid = 1'b1;
    p_data = 8'h81;
    repeat (3) @(posedge clck);
    @(negedge clck);
    total_cnt++;
    if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL reset: tx_out=%b busy=%b, required 1/0", tx_out, busy);
    else pass_cnt++;
    @(posedge clck); #1;
    rst = 1'b0;
    data_valid = 1'b0;
    mon_en = 1;
    repeat (4) @(negedge clck);
  endtask

  task automatic test_no_parity();
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    wait_done();
  endtask

  task automatic test_parity();
    send(8'hA5, 1'b1, 1'b0, 6'd16);
    wait_done();
    send(8'hA5, 1'b1, 1'b1, 6'd16);
    wait_done();
    send(8'h00, 1'b1, 1'b1, 6'd1);
    wait_done();
    send(8'h3B, 1'b1, 1'b0, 6'd0);
    wait_done();
    send(8'hC7, 1'b0, 1'b0, 6'd63);
    wait_done();
  endtask

  task automatic test_ignore_busy();
    int f0 = frames;
    send(8'h3C, 1'b0, 1'b0, 6'd8);
    repeat (20) @(posedge clck);
    #1;
    p_data = 8'hFF; prescale = 6'd4; par_en = 1'b1; data_valid = 1'b1;
    @(posedge clck); #1;
    data_valid = 1'b0;
    wait_done();
    repeat (10) @(negedge clck);
    total_cnt++;
    if (frames !== f0 + 1) $display("FAIL ignore_busy frames: got %0d, required %0d", frames - f0, 1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    send(8'h96, 1'b0, 1'b0, 6'd8);
    repeat (28) @(posedge clck);
    #1;
    rst = 1'b1;
    @(posedge clck); #1;
    rst = 1'b0;
    @(negedge clck);
    total_cnt++;
    if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL reset_mid: tx_out=%b busy=%b, required 1/0", tx_out, busy);
    else pass_cnt++;
    repeat (3) @(negedge clck);
    send(8'hC3, 1'b1, 1'b1, 6'd8);
    wait_done();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   f0 = frames;
    @(posedge clck); #1;
    p_data = 8'h55; prescale = 6'd4; par_en = 1'b0; data_valid = 1'b1;
    e.d = 8'h55; e.pe = 1'b0; e.par = 1'b0; e.p = 4;
    sb.push_back(e);
    @(posedge clck); #1;
    p_data = 8'hAA;
    e.d = 8'hAA;
    sb.push_back(e);
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clck);
    @(posedge clck); #1;
    data_valid = 1'b0;
    wait_done();
    total_cnt++;
    if (last_gap !== 1) $display("FAIL back_to_back gap: got %0d idle cycles, required 1", last_gap);
    else pass_cnt++;
    total_cnt++;
    if (frames !== f0 + 2) $display("FAIL back_to_back frames: got %0d, required 2", frames - f0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial UART transmitter. It is the transmit-side counterpart of the UART receive path in the same system.
- Accepts a parallel byte with a single-cycle valid and serializes it onto tx_out as one frame: start bit, 8 data bits LSB-first, optional parity bit, stop bit.
- Each bit lasts `prescale` clck cycles, matching the receiver's oversampling configuration, so both ends share one fast clock and one prescale setting.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (the only value verified is 8)

Ports:
clck  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
p_data  input  DATA_WIDTH  parallel byte to transmit
data_valid  input  1  request strobe; p_data is valid while high
par_en  input  1  1 = insert parity bit after data bits
par_typ  input  1  0 = even parity, 1 = odd parity
prescale  input  6  clck cycles per bit; 0 is treated as 1
tx_out  output  1  serial line, idle high, registered
busy  output  1  high while a frame is in flight, registered

Behaviour:
- Reset: one clock, synchronous, active-high.
  - When rst=1 at a clck edge: state=IDLE, tx_out=1, busy=0, all counters and shadow registers cleared.
  - Reset mid-frame aborts the frame immediately; tx_out returns to 1 on that edge.
- States: IDLE, START, DATA, PARITY, STOP. Encoding is implementer's choice; unused encodings return to IDLE.
- Accept:
  - At an edge where state=IDLE and data_valid=1, capture p_data, par_en, par_typ and prescale (0 mapped to 1) into shadow registers.
  - Compute parity from the captured byte: even = XOR of bits; odd = inverted XOR.
  - On the same edge: state goes to START, tx_out=0, busy=1, bit-timer=1.
- While busy:
  - data_valid is ignored; it is neither queued nor acknowledged.
  - Changes on p_data, par_en, par_typ and prescale have no effect on the current frame.
- Bit timer:
  - Counts 1..P, where P is the captured prescale.
  - When timer=P, the next edge advances to the next bit, resets the timer to 1, and updates tx_out.
  - Otherwise the timer increments and tx_out holds.
- Transitions:
  - START -> DATA. tx_out = bit 0.
  - DATA: a bit index 0..7 advances on each bit boundary; tx_out = data[index].
  - After bit 7, go to PARITY if captured par_en=1, else to STOP.
  - PARITY -> STOP.
  - STOP: tx_out=1 for P cycles.
  - At the end of STOP: state goes to IDLE and busy=0. tx_out stays 1.
- Latency and timing:
  - tx_out falls on the accept edge.
  - The frame occupies exactly P*N cycles: N=10 without parity, N=11 with parity.
  - busy is high for exactly those P*N cycles.
- Back-to-back frames:
  - A new accept is possible on the first edge where state=IDLE.
  - This gives a minimum of one idle-high cycle between frames.
  - data_valid held high continuously therefore sends frames separated by one cycle, each capturing the p_data present at its accept edge.
- Simultaneous events: rst=1 with data_valid=1 means reset wins and nothing is accepted.
- Width rules:
  - The bit-timer is 6 bits and compares against the captured prescale; it never wraps because P≤63.
  - The bit index is 3 bits and wraps 7->0 only on leaving DATA.

Test Plan:
- p_data=0xA5, par_en=0, prescale=8 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles. busy high exactly 80 cycles; tx_out=1 afterwards.
- p_data=0xA5, par_en=1, par_typ=0, prescale=16 -> parity bit = 0, frame 176 cycles. Repeat with par_typ=1 -> parity bit = 1.
- p_data=0x00, par_en=1, par_typ=1, prescale=1 -> tx_out over 11 cycles = 0,0,0,0,0,0,0,0,0,1,1.
- During a frame of 0x3C, pulse data_valid with p_data=0xFF and change prescale 8->4 -> frame remains 0x3C at 8 cycles/bit, and no second frame follows.
- rst=1 asserted in cycle 30 of an 80-cycle frame -> next edge gives tx_out=1 and busy=0. A new data_valid after reset releases produces a complete correct frame.
- data_valid held high with 0x55 then 0xAA, prescale=4, par_en=0 -> two 40-cycle frames separated by exactly one idle-high cycle.
